pc_gen: RTL and testbench

Parametrised program-counter generator for the MIPS32 fetch stage, successor to the fixed 32-bit PC register. It holds the fetch address, advances by a configurable instruction size, and redirects on branch or pipeline flush. Unlike its predecessor, it supports stalls and instruction-memory back-pressure, buffers a branch that arrives while fetch is held, and flags misaligned targets. It sits between the ID-stage branch resolver and the instruction-memory interface.

---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/pc_gen_pend_buf.sv | 44 ++++
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
// Shared constants and types for the fetch-stage program-counter generator:
// chip-enable levels, the branch-taken level and the two-state fetch FSM.
package pc_gen_pkg;

    // Instruction-memory chip-enable levels
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Level of branch_flag_i that means "branch taken"
    localparam logic BRANCH = 1'b1;

    // Default fetch address width for MIPS32 instances
    localparam int INST_ADDR_W = 32;

    // HOLD: memory disabled after reset; RUN: normal fetch
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pc_gen_pend_buf.sv
// pc_gen_pend_buf
// Single-entry branch-target buffer: a valid bit plus a target register.
// Holds a taken branch that arrived while fetch could not advance.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (clears valid only)
//   load   in   capture din and set valid (a later load overwrites)
//   clear  in   drop the buffered target; wins over load
//   din    in   ADDR_W  target to capture
//   valid  out  buffer holds a target
//   target out  ADDR_W  buffered target
module pc_gen_pend_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] din,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // The target register is only meaningful while valid is set, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (load && !clear) begin
            target <= din;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen
// Program-counter generator for the MIPS32 fetch stage. Holds the fetch
// address, advances by INST_BYTES when memory accepts it, redirects on flush
// or taken branch, buffers a branch that arrives while fetch is held, and
// flags misaligned fetch addresses.
// Ports:
//   clk                  in   clock
//   rst                  in   asynchronous active-high reset
//   stall_i              in   pipeline hold
//   if_ready_i           in   instruction memory accepts current address
//   branch_flag_i        in   branch taken (compared against BRANCH)
//   branch_target_addr_i in   ADDR_W  branch destination
//   flush_i              in   exception/eret redirect
//   flush_pc_i           in   ADDR_W  redirect destination
//   pc                   out  ADDR_W  current fetch address (registered)
//   ce                   out  instruction-memory chip enable (registered)
//   addr_err_o           out  current pc misaligned (registered)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = INST_ADDR_W,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              if_ready_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_addr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              addr_err_o
);

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    // Low log2(INST_BYTES) bits nonzero; always 0 for byte-sized instructions
    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    state_t            state;
    logic              adv;
    logic              branch_taken;
    logic              load_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              pend_load;
    logic              pend_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    pc_gen_pend_buf #(
        .ADDR_W (ADDR_W)
    ) u_pend_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (pend_load),
        .clear  (pend_clear),
        .din    (branch_target_addr_i),
        .valid  (pend_valid),
        .target (pend_target)
    );

    // Next-PC selection. Flush ignores stall/back-pressure; everything else
    // only moves the PC on an advance edge. A branch that cannot advance is
    // parked in the pending buffer instead of being lost.
    always_comb begin
        adv          = (ce == CHIP_ENABLE) && !stall_i && if_ready_i;
        branch_taken = (branch_flag_i == BRANCH);
        load_pc      = 1'b0;
        next_pc      = pc;
        pend_load    = 1'b0;
        pend_clear   = 1'b0;
        if (state == ST_RUN) begin
            if (flush_i) begin
                load_pc    = 1'b1;
                next_pc    = flush_pc_i;
                pend_clear = 1'b1;
            end else if (adv && branch_taken) begin
                load_pc    = 1'b1;
                next_pc    = branch_target_addr_i;
                pend_clear = 1'b1;
            end else if (adv && pend_valid) begin
                load_pc    = 1'b1;
                next_pc    = pend_target;
                pend_clear = 1'b1;
            end else if (adv) begin
                load_pc    = 1'b1;
                next_pc    = pc + PC_INC;
            end else if (branch_taken) begin
                pend_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            ce         <= CHIP_DISABLE;
            pc         <= RESET_VEC;
            addr_err_o <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    state <= ST_RUN;
                    ce    <= CHIP_ENABLE;
                end
                default: begin
                    state <= ST_RUN;
                    ce    <= CHIP_ENABLE;
                end
            endcase
            if (load_pc) begin
                pc         <= next_pc;
                addr_err_o <= misaligned(next_pc);
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen
// Self-checking bench for pc_gen (ADDR_W=32, INST_BYTES=4, RESET_VEC=0).
// Directed scenarios followed by random traffic, all checked against a
// rule-level reference model with a queue as the pending branch store.
module tb_pc_gen;

    localparam int          ADDR_W     = 32;
    localparam int          INST_BYTES = 4;
    localparam logic [31:0] RESET_VEC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        if_ready_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_addr_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [31:0] pc;
    logic        ce;
    logic        addr_err_o;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] pend_q[$];

    pc_gen #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES),
        .RESET_VEC  (RESET_VEC)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_i              (stall_i),
        .if_ready_i           (if_ready_i),
        .branch_flag_i        (branch_flag_i),
        .branch_target_addr_i (branch_target_addr_i),
        .flush_i              (flush_i),
        .flush_pc_i           (flush_pc_i),
        .pc                   (pc),
        .ce                   (ce),
        .addr_err_o           (addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ce"}, {31'b0, ce}, {31'b0, m_run});
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".err"}, {31'b0, addr_err_o}, {31'b0, m_err});
    endtask

    function automatic logic bad_align(input logic [31:0] a);
        return (a % INST_BYTES) != 0;
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RESET_VEC;
        m_err = 1'b0;
        pend_q.delete();
    endtask

    task automatic model_load(input logic [31:0] a);
        m_pc  = a;
        m_err = bad_align(a);
    endtask

    // One rising edge, written straight from the priority rules
    task automatic model_edge();
        bit adv;
        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else begin
            adv = !stall_i && if_ready_i;
            if (flush_i) begin
                model_load(flush_pc_i);
                pend_q.delete();
            end else if (adv && branch_flag_i) begin
                model_load(branch_target_addr_i);
                pend_q.delete();
            end else if (adv && pend_q.size() > 0) begin
                model_load(pend_q[$]);
                pend_q.delete();
            end else if (adv) begin
                model_load(32'((64'(m_pc) + INST_BYTES) % 64'h1_0000_0000));
            end else if (branch_flag_i) begin
                pend_q.push_back(branch_target_addr_i);
            end
        end
    endtask

    task automatic drive(input logic st, input logic rdy, input logic br,
                         input logic [31:0] bt, input logic fl, input logic [31:0] fpc);
        stall_i              = st;
        if_ready_i           = rdy;
        branch_flag_i        = br;
        branch_target_addr_i = bt;
        flush_i              = fl;
        flush_pc_i           = fpc;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] t;
        model_reset();
        drive(0, 1, 0, '0, 0, '0);

        // Reset and release, then three advancing cycles
        step("rst0");
        check("rst_pc", pc, 32'h0);
        rst = 1'b0;
        step("release");
        check("release_pc", pc, 32'h0);
        step("adv1");
        check("adv1_pc", pc, 32'h4);
        step("adv2");
        step("adv3");
        check("adv3_pc", pc, 32'hC);

        // Branch buffered under stall, released later
        drive(1, 1, 1, 32'h100, 0, '0);
        step("stall_br1");
        drive(1, 1, 0, 32'h0, 0, '0);
        step("stall_br2");
        step("stall_br3");
        check("stall_hold_pc", pc, 32'hC);
        drive(0, 1, 0, '0, 0, '0);
        step("pend_take");
        check("pend_take_pc", pc, 32'h100);
        step("pend_next");
        check("pend_next_pc", pc, 32'h104);

        // Two branches under back-pressure: last wins
        drive(0, 0, 1, 32'h200, 0, '0);
        step("bp_br1");
        drive(0, 0, 1, 32'h300, 0, '0);
        step("bp_br2");
        drive(0, 1, 0, '0, 0, '0);
        step("bp_take");
        check("last_wins_pc", pc, 32'h300);

        // Flush with simultaneous branch while stalled
        drive(1, 1, 1, 32'h40, 1, 32'h8000_0180);
        step("flush");
        check("flush_pc", pc, 32'h8000_0180);
        drive(1, 1, 0, '0, 0, '0);
        step("flush_hold");
        drive(0, 1, 0, '0, 0, '0);
        step("flush_adv");
        check("flush_adv_pc", pc, 32'h8000_0184);

        // Wrap and misalignment
        drive(0, 1, 0, '0, 1, 32'hFFFF_FFFC);
        step("to_top");
        drive(0, 1, 0, '0, 0, '0);
        step("wrap");
        check("wrap_pc", pc, 32'h0);
        check("wrap_err", {31'b0, addr_err_o}, 32'h0);
        drive(0, 1, 1, 32'h102, 0, '0);
        step("misalign");
        check("misalign_err", {31'b0, addr_err_o}, 32'h1);
        drive(0, 1, 0, '0, 0, '0);
        step("misalign_inc");

        // Asynchronous reset mid-run with a buffered branch
        drive(1, 1, 1, 32'h700, 0, '0);
        step("pre_rst_buf");
        drive(0, 1, 0, '0, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_hold");
        rst = 1'b0;
        // Redirects in HOLD are ignored
        drive(0, 1, 1, 32'h500, 1, 32'h600);
        step("rerelease");
        drive(0, 1, 0, '0, 0, '0);
        step("no_stale1");
        check("no_stale_pc", pc, 32'h4);
        step("no_stale2");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] f;
            t = $urandom();
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            f = $urandom();
            if ($urandom_range(0, 3) != 0) f[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, t,
                  $urandom_range(0, 15) == 0, f);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
